// File: rtl/countdown_pkg.sv
// Shared types and helpers for the BCD countdown controller.
// Holds the controller state encoding, chain geometry and the preset nibble clamp.
package countdown_pkg;

   localparam int               BCD_DIGITS = 4;
   localparam logic [15:0]      BCD_ZERO   = 16'h0000;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PAUSE,
      RUN,
      DONE
   } state_e;

   function automatic logic [3:0] clamp_nibble(input logic [3:0] n);
      return (n > 4'd9) ? 4'd9 : n;
   endfunction

   function automatic logic [BCD_DIGITS*4-1:0] clamp_bcd(input logic [BCD_DIGITS*4-1:0] v);
      logic [BCD_DIGITS*4-1:0] r;
      r = '0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         r[i*4 +: 4] = clamp_nibble(v[i*4 +: 4]);
      end
      return r;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-TICK_DIV timebase counter; clear has priority over enable and holds when disabled.
// tc_o is high for the single enabled cycle in which the count sits at TICK_DIV-1.
module tick_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic tc_o
);

   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// Sequencer for a 4-digit BCD down-counter chain: preset, per-tick borrow, stop at 0000.
// All outputs registered; optional alarm pulse after reaching zero is built with ALARM_EN.
module bcd_countdown_ctrl
   import countdown_pkg::*;
#(
   parameter int TICK_DIV    = 50_000_000,
   parameter int ALARM_TICKS = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    start,
   input  logic [BCD_DIGITS*4-1:0] set_bcd,
   input  logic [BCD_DIGITS*4-1:0] cnt_bcd,
   output logic                    preset,
   output logic                    bin,
   output logic [BCD_DIGITS*4-1:0] preset_bcd,
   output logic                    running,
   output logic                    done,
   output logic                    alarm
);

   if (TICK_DIV < 2) begin : g_bad_div
      $error("TICK_DIV must be at least 2");
   end
   if (ALARM_TICKS < 1) begin : g_bad_alarm
      $error("ALARM_TICKS must be at least 1");
   end

   state_e                  state_q, state_d;
   logic                    preset_q, bin_q, running_q, done_q;
   logic                    bin_d;
   logic [BCD_DIGITS*4-1:0] preset_bcd_q, preset_bcd_d;
   logic                    cnt_zero, done_entry;
   logic                    run_en, pre_en, pre_clr, tc;

   assign cnt_zero   = (cnt_bcd == BCD_ZERO);
   assign done_entry = (state_d == DONE) && (state_q != DONE);

   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = LOAD;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            LOAD:    state_d = PAUSE;
            PAUSE:   if (start) state_d = cnt_zero ? DONE : RUN;
            RUN: begin
               if (start) begin
                  state_d = PAUSE;
               end else if (cnt_zero) begin
                  state_d = DONE;
               end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   // A start in RUN freezes the prescaler on that very cycle, so a coincident tick is lost
   assign run_en  = (state_q == RUN) && !start && !load;
   assign pre_clr = load || (state_q == LOAD) || done_entry;
   assign bin_d   = (state_q == RUN) && tc && !cnt_zero;
   assign preset_bcd_d = load ? clamp_bcd(set_bcd) : preset_bcd_q;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .en_i  (pre_en),
      .clr_i (pre_clr),
      .tc_o  (tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         preset_q     <= 1'b0;
         bin_q        <= 1'b0;
         running_q    <= 1'b0;
         done_q       <= 1'b0;
         preset_bcd_q <= '0;
      end else begin
         state_q      <= state_d;
         preset_q     <= (state_d == LOAD);
         bin_q        <= bin_d;
         running_q    <= (state_d == RUN);
         done_q       <= (state_d == DONE);
         preset_bcd_q <= preset_bcd_d;
      end
   end

`ifdef ALARM_EN
   localparam int AW = $clog2(ALARM_TICKS + 1);

   logic          alarm_q, alarm_d;
   logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;

   // The prescaler keeps running in DONE only to time the alarm, restarted from 0 on entry
   assign pre_en = run_en || ((state_q == DONE) && alarm_q);

   always_comb begin
      alarm_d     = alarm_q;
      alarm_cnt_d = alarm_cnt_q;
      if (state_d == LOAD) begin
         alarm_d     = 1'b0;
         alarm_cnt_d = '0;
      end else if (done_entry) begin
         alarm_d     = 1'b1;
         alarm_cnt_d = '0;
      end else if (alarm_q && tc) begin
         if (alarm_cnt_q == AW'(ALARM_TICKS - 1)) begin
            alarm_d = 1'b0;
         end else begin
            alarm_cnt_d = alarm_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_q     <= 1'b0;
         alarm_cnt_q <= '0;
      end else begin
         alarm_q     <= alarm_d;
         alarm_cnt_q <= alarm_cnt_d;
      end
   end

   assign alarm = alarm_q;
`else
   assign pre_en = run_en;
   assign alarm  = 1'b0;
`endif

   assign preset     = preset_q;
   assign bin        = bin_q;
   assign preset_bcd = preset_bcd_q;
   assign running    = running_q;
   assign done       = done_q;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// Bench for bcd_countdown_ctrl with a behavioural counter chain and an event scoreboard.
module tb_bcd_countdown_ctrl;

   typedef struct {
      int          cyc;
      logic [15:0] val;
   } evt_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic        start;
   logic [15:0] set_bcd;
   logic [15:0] cnt_bcd = 16'h0000;
   logic        preset, bin, running, done, alarm;
   logic [15:0] preset_bcd;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   evt_t exp_preset_q[$];
   evt_t exp_bin_q[$];
   int   exp_done_q[$];
   int   exp_arise_q[$];
   int   exp_afall_q[$];
   logic done_prev = 1'b0;
   logic alarm_prev = 1'b0;

   bcd_countdown_ctrl #(
      .TICK_DIV    (4),
      .ALARM_TICKS (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .start      (start),
      .set_bcd    (set_bcd),
      .cnt_bcd    (cnt_bcd),
      .preset     (preset),
      .bin        (bin),
      .preset_bcd (preset_bcd),
      .running    (running),
      .done       (done),
      .alarm      (alarm)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < 4; i++) begin
         if (r[i*4 +: 4] != 4'd0) begin
            r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
            break;
         end
         r[i*4 +: 4] = 4'd9;
      end
      return r;
   endfunction

   function automatic logic [15:0] sat_bcd(input logic [15:0] v);
      logic [15:0] r;
      logic [3:0]  n;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         n = v[i*4 +: 4];
         r[i*4 +: 4] = (n[3] && (n[2] || n[1])) ? 4'd9 : n;
      end
      return r;
   endfunction

   // Counter chain behaviour: preset wins, otherwise one BCD decrement per borrow
   always @(posedge clk) begin
      if (preset) cnt_bcd <= preset_bcd;
      else if (bin) cnt_bcd <= bcd_dec(cnt_bcd);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      evt_t e;
      int   c;
      if (preset === 1'b1) begin
         if (exp_preset_q.size() == 0) chk("preset_unexpected", 32'(preset), 32'd0);
         else begin
            e = exp_preset_q.pop_front();
            chk("preset_cycle", 32'(cyc), 32'(e.cyc));
            chk("preset_value", 32'(preset_bcd), 32'(e.val));
         end
      end
      if (bin === 1'b1) begin
         if (exp_bin_q.size() == 0) chk("bin_unexpected", 32'(bin), 32'd0);
         else begin
            e = exp_bin_q.pop_front();
            chk("bin_cycle", 32'(cyc), 32'(e.cyc));
            chk("bin_chain_value", 32'(cnt_bcd), 32'(e.val));
         end
      end
      if (done === 1'b1 && done_prev === 1'b0) begin
         if (exp_done_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
         else begin
            c = exp_done_q.pop_front();
            chk("done_rise_cycle", 32'(cyc), 32'(c));
         end
      end
      if (alarm === 1'b1 && alarm_prev === 1'b0) begin
         if (exp_arise_q.size() == 0) chk("alarm_unexpected", 32'(alarm), 32'd0);
         else begin
            c = exp_arise_q.pop_front();
            chk("alarm_rise_cycle", 32'(cyc), 32'(c));
         end
      end
      if (alarm === 1'b0 && alarm_prev === 1'b1) begin
         if (exp_afall_q.size() == 0) chk("alarm_fall_unexpected", 32'(alarm), 32'd1);
         else begin
            c = exp_afall_q.pop_front();
            chk("alarm_fall_cycle", 32'(cyc), 32'(c));
         end
      end
      done_prev  = done;
      alarm_prev = alarm;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) tick();
   endtask

   task automatic at_neg(input int n);
      wait_cyc(n);
      @(negedge clk);
   endtask

   task automatic do_load(input int at, input logic [15:0] v);
      wait_cyc(at);
      load    = 1'b1;
      set_bcd = v;
      exp_preset_q.push_back('{cyc: at + 1, val: sat_bcd(v)});
      tick();
      load = 1'b0;
   endtask

   task automatic do_start(input int at);
      wait_cyc(at);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, "_preset_pending"}, 32'(exp_preset_q.size()), 32'd0);
      chk({tag, "_bin_pending"}, 32'(exp_bin_q.size()), 32'd0);
      chk({tag, "_done_pending"}, 32'(exp_done_q.size()), 32'd0);
      chk({tag, "_alarm_pending"}, 32'(exp_arise_q.size() + exp_afall_q.size()), 32'd0);
   endtask

   initial begin
      int t, s, r, l, a;
      rst     = 1'b1;
      load    = 1'b0;
      start   = 1'b0;
      set_bcd = 16'h0000;

      at_neg(2);
      chk("rst_preset", 32'(preset), 32'd0);
      chk("rst_bin", 32'(bin), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_alarm", 32'(alarm), 32'd0);
      chk("rst_preset_bcd", 32'(preset_bcd), 32'd0);
      wait_cyc(3);
      rst = 1'b0;

      do_start(5);
      at_neg(6);
      chk("idle_start_ignored", 32'(running), 32'd0);

      // Count 0003 down to zero: three borrows, then DONE, no wrap
      t = 8;
      s = t + 2;
      do_load(t, 16'h0003);
      exp_bin_q.push_back('{cyc: s + 5,  val: 16'h0003});
      exp_bin_q.push_back('{cyc: s + 9,  val: 16'h0002});
      exp_bin_q.push_back('{cyc: s + 13, val: 16'h0001});
      exp_done_q.push_back(s + 15);
`ifdef ALARM_EN
      exp_arise_q.push_back(s + 15);
      exp_afall_q.push_back(s + 27);
`endif
      do_start(s);
      at_neg(s + 1);
      chk("run_after_start", 32'(running), 32'd1);
      at_neg(s + 15);
      chk("done_at_zero", 32'(done), 32'd1);
      chk("not_running_in_done", 32'(running), 32'd0);
      at_neg(s + 30);
      chk("chain_held_at_zero", 32'(cnt_bcd), 32'h0000);
      chk("alarm_off_late", 32'(alarm), 32'd0);
      chk_drained("count3");

      // Clamping of out-of-range nibbles, random values then the fixed one
      t = s + 31;
      for (int i = 0; i < 3; i++) do_load(t + 2 * i, 16'($urandom));
      t = t + 6;
      do_load(t, 16'h1A0F);
      at_neg(t + 1);
      chk("clamp_1A0F", 32'(preset_bcd), 32'h1909);
      chk("load_exits_done", 32'(done), 32'd0);

      // Pause after two prescaler steps, resume after 20 cycles
      s = t + 2;
      do_start(s);
      do_start(s + 3);
      at_neg(s + 4);
      chk("paused", 32'(running), 32'd0);
      r = s + 24;
      exp_bin_q.push_back('{cyc: r + 3, val: 16'h1909});
      do_start(r);
      at_neg(r + 1);
      chk("resumed", 32'(running), 32'd1);

      // start on the terminal-count cycle swallows that tick
      do_start(r + 6);
      at_neg(r + 7);
      chk("tc_start_paused", 32'(running), 32'd0);
      at_neg(r + 9);
      chk("tc_start_no_dec", 32'(cnt_bcd), 32'h1908);
      chk_drained("pause");

      // Reset in the middle of RUN
      l = r + 11;
      do_load(l, 16'h0042);
      do_start(l + 2);
      wait_cyc(l + 5);
      rst = 1'b1;
      at_neg(l + 6);
      chk("midrst_running", 32'(running), 32'd0);
      chk("midrst_bin", 32'(bin), 32'd0);
      chk("midrst_preset", 32'(preset), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_alarm", 32'(alarm), 32'd0);
      chk("midrst_preset_bcd", 32'(preset_bcd), 32'd0);
      wait_cyc(l + 7);
      rst = 1'b0;
      do_start(l + 9);
      at_neg(l + 11);
      chk("post_rst_start_ignored", 32'(running), 32'd0);
      at_neg(l + 14);
      chk("post_rst_still_idle", 32'(running), 32'd0);
      chk_drained("midrst");

      // Start with the chain already at zero, start ignored in DONE, load clears alarm
      a = l + 16;
      do_load(a, 16'h0000);
      exp_done_q.push_back(a + 3);
`ifdef ALARM_EN
      exp_arise_q.push_back(a + 3);
      exp_afall_q.push_back(a + 7);
`endif
      do_start(a + 2);
      at_neg(a + 3);
      chk("zero_start_done", 32'(done), 32'd1);
      chk("zero_start_not_run", 32'(running), 32'd0);
      do_start(a + 4);
      at_neg(a + 5);
      chk("done_start_ignored", 32'(done), 32'd1);
      chk("done_start_not_run", 32'(running), 32'd0);
      do_load(a + 6, 16'h0005);
      at_neg(a + 7);
      chk("load_clears_done", 32'(done), 32'd0);
      chk("load_clears_alarm", 32'(alarm), 32'd0);
      at_neg(a + 10);
      chk("final_chain_value", 32'(cnt_bcd), 32'h0005);
      chk_drained("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
